// File: rtl/mont_convert.sv
// rtl/mont_convert.sv - pipelined Montgomery-domain converter sharing one REDC core
//
// Purpose: converts coefficients into Montgomery form (mode 1: REDC(a * R2_MOD) = a*R mod q)
// and out of it (mode 0: REDC(T) = T*R^-1 mod q), R = 2^MODULUS_LENGTH, through a
// three-stage pipeline with valid/ready streams on both sides.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   in_valid_i/in_ready_o  input handshake
//   in_mode_i              0 = from-Montgomery, 1 = to-Montgomery
//   in_data_i              T (bits [2k-1:0]) or a (bits [k-1:0])
//   in_tag_i               sideband tag, returned with the result
//   out_valid_o/out_ready_i output handshake
//   out_data_o             result in [0, q-1], zero-extended
//   out_tag_o              tag of the result

package params_pkg;
   localparam int LENGTH         = 64;
   localparam int MODULUS_LENGTH = 23;
   localparam int MODULUS        = 8380417;
   localparam int MOD_INV        = -8193;
endpackage

module mont_convert #(
   parameter int LENGTH         = params_pkg::LENGTH,
   parameter int MODULUS_LENGTH = params_pkg::MODULUS_LENGTH,
   parameter int MODULUS        = params_pkg::MODULUS,
   parameter int MOD_INV        = params_pkg::MOD_INV,
   parameter int R2_MOD         = 49145,
   parameter int TAG_W          = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              in_mode_i,
   input  logic [LENGTH-1:0] in_data_i,
   input  logic [TAG_W-1:0]  in_tag_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [LENGTH-1:0] out_data_o,
   output logic [TAG_W-1:0]  out_tag_o
);

   localparam int K  = MODULUS_LENGTH;
   localparam int TW = 2 * K;

   localparam logic [K-1:0]  Q_K    = MODULUS[K-1:0];
   localparam logic [K-1:0]  MINV_K = MOD_INV[K-1:0];
   localparam logic [K-1:0]  R2_K   = R2_MOD[K-1:0];
   localparam logic [TW:0]   Q_W    = {{(K+1){1'b0}}, Q_K};

   // Pipeline registers
   logic              s1_valid_q, s2_valid_q, out_valid_q;
   logic [TW-1:0]     s1_t_q, s2_t_q;
   logic [K-1:0]      s2_m_q;
   logic [K-1:0]      out_data_q;
   logic [TAG_W-1:0]  s1_tag_q, s2_tag_q, out_tag_q;

   // Next-state values
   logic [TW-1:0]     s1_t_d;
   logic [K-1:0]      s2_m_d;
   logic [K-1:0]      out_data_d;

   logic              stall;
   logic              advance;
   logic [K-1:0]      a_in;
   logic [TW:0]       s3_mq;
   logic [TW:0]       s3_sum;
   logic [K:0]        s3_t;
   logic [K:0]        s3_red;
   logic              unused_bits;

   // The whole pipeline freezes as one unit; bubbles are kept so the
   // occupancy under backpressure never exceeds three beats.
   assign stall      = out_valid_q && !out_ready_i;
   assign advance    = !stall;
   assign in_ready_o = advance;

   // S1: select T. In mode 1 the a*R2_MOD product makes REDC return a*R mod q.
   assign a_in   = in_data_i[K-1:0];
   assign s1_t_d = in_mode_i ? ({{K{1'b0}}, a_in} * {{K{1'b0}}, R2_K})
                             : in_data_i[TW-1:0];

   // S2: m = T_low * (-q^-1) mod R; the K-bit product width performs the mod R.
   assign s2_m_d = s1_t_q[K-1:0] * MINV_K;

   // S3: T + m*q is divisible by R; one extra bit keeps the carry of the sum.
   assign s3_mq      = {{(K+1){1'b0}}, s2_m_q} * Q_W;
   assign s3_sum     = {1'b0, s2_t_q} + s3_mq;
   assign s3_t       = s3_sum[TW:K];
   assign s3_red     = (s3_t >= {1'b0, Q_K}) ? (s3_t - {1'b0, Q_K}) : s3_t;
   assign out_data_d = s3_red[K-1:0];

   // Low sum bits are zero by construction and the reduced top bit is zero in range.
   assign unused_bits = ^{in_data_i, s3_sum[K-1:0], s3_red[K]};

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         s1_t_q      <= '0;
         s2_t_q      <= '0;
         s2_m_q      <= '0;
         out_data_q  <= '0;
         s1_tag_q    <= '0;
         s2_tag_q    <= '0;
         out_tag_q   <= '0;
      end else if (advance) begin
         s1_valid_q  <= in_valid_i;
         s2_valid_q  <= s1_valid_q;
         out_valid_q <= s2_valid_q;
         if (in_valid_i) begin
            s1_t_q   <= s1_t_d;
            s1_tag_q <= in_tag_i;
         end
         if (s1_valid_q) begin
            s2_t_q   <= s1_t_q;
            s2_m_q   <= s2_m_d;
            s2_tag_q <= s1_tag_q;
         end
         // Output data only changes when a new result lands, so it holds through bubbles.
         if (s2_valid_q) begin
            out_data_q <= out_data_d;
            out_tag_q  <= s2_tag_q;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = {{(LENGTH-K){1'b0}}, out_data_q};
   assign out_tag_o   = out_tag_q;

endmodule
